// File: rtl/ands_asr_adder.sv
// Single-cycle 32-bit ALU slice: ANDS, ASR, ADDS and ADCS with registered result and NZCV flags.
// A request is accepted on any rising edge with in_valid high; idle cycles hold result/flags.
module ands_asr_adder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [1:0]  op,
  input  logic [31:0] num1,
  input  logic [31:0] num2,
  output logic [31:0] result,
  output logic [3:0]  flags,
  output logic        out_valid
);

  localparam int unsigned DW = 32;
  localparam int unsigned SW = 5;

  localparam int unsigned FN = 0;
  localparam int unsigned FZ = 1;
  localparam int unsigned FC = 2;
  localparam int unsigned FV = 3;

  typedef enum logic [1:0] {
    OP_ANDS = 2'b00,
    OP_ASR  = 2'b01,
    OP_ADDS = 2'b10,
    OP_ADCS = 2'b11
  } op_e;

  logic [DW-1:0] next_result;
  logic [3:0]    next_flags;
  logic [SW-1:0] shamt;
  logic [DW:0]   sum;
  logic          carry_in;

  // Next result/flags from the current operands and the pre-edge flag register.
  always_comb begin
    next_result = result;
    next_flags  = flags;
    shamt       = num2[SW-1:0];
    carry_in    = 1'b0;
    sum         = '0;

    unique case (op_e'(op))
      OP_ANDS: begin
        next_result     = num1 & num2;
        next_flags[FC]  = 1'b0;
      end
      OP_ASR: begin
        next_result = DW'($signed(num1) >>> shamt);
        // A zero shift moves no bit out, so the carry is left alone.
        if (shamt != '0) begin
          next_flags[FC] = num1[SW'(shamt - SW'(1))];
        end
      end
      OP_ADDS, OP_ADCS: begin
        carry_in        = (op_e'(op) == OP_ADCS) ? flags[FC] : 1'b0;
        sum             = {1'b0, num1} + {1'b0, num2} + (DW+1)'(carry_in);
        next_result     = sum[DW-1:0];
        next_flags[FC]  = sum[DW];
        next_flags[FV]  = (num1[DW-1] == num2[DW-1]) && (sum[DW-1] != num1[DW-1]);
      end
      default: begin
        next_result = result;
      end
    endcase

    next_flags[FN] = next_result[DW-1];
    next_flags[FZ] = (next_result == '0);
  end

  // Output registers; reset wins over any request presented on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result    <= '0;
      flags     <= '0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      result    <= next_result;
      flags     <= next_flags;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ands_asr_adder.sv
// Scoreboard bench for ands_asr_adder: directed cases from the requirements plus randomized traffic
// checked against an arithmetic reference model of the NZCV rules.
module tb_ands_asr_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [1:0]  op;
  logic [31:0] num1;
  logic [31:0] num2;
  logic [31:0] result;
  logic [3:0]  flags;
  logic        out_valid;

  typedef struct {
    logic        v;
    logic [31:0] r;
    logic [3:0]  f;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_res;
  logic [3:0]  m_flags;
  int          checks;
  int          failures;

  ands_asr_adder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .op        (op),
    .num1      (num1),
    .num2      (num2),
    .result    (result),
    .flags     (flags),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: flags {V,C,Z,N}, derived from signed/unsigned arithmetic on wide integers.
  task automatic model(input logic rst, input logic v, input logic [1:0] o,
                       input logic [31:0] a, input logic [31:0] b);
    exp_t            e;
    logic [31:0]     r;
    logic            n, z, c, ov;
    int              sh;
    longint unsigned us;
    longint          ss;
    c  = m_flags[2];
    ov = m_flags[3];
    r  = m_res;
    if (!rst) begin
      m_res   = '0;
      m_flags = '0;
      e.v     = 1'b0;
    end else if (!v) begin
      e.v = 1'b0;
    end else begin
      case (o)
        2'b00: begin
          r = a & b;
          c = 1'b0;
        end
        2'b01: begin
          sh = int'(b[4:0]);
          for (int i = 0; i < 32; i++) r[i] = (i + sh < 32) ? a[i + sh] : a[31];
          if (sh != 0) c = a[sh - 1];
        end
        default: begin
          us = 64'(a) + 64'(b) + ((o == 2'b11) ? 64'(m_flags[2]) : 64'd0);
          ss = longint'($signed(a)) + longint'($signed(b)) + ((o == 2'b11) ? longint'(m_flags[2]) : 64'sd0);
          r  = us[31:0];
          c  = (us >= 64'h1_0000_0000);
          ov = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
        end
      endcase
      n       = r[31];
      z       = (r == 32'd0);
      m_res   = r;
      m_flags = {ov, c, z, n};
      e.v     = 1'b1;
    end
    e.r = m_res;
    e.f = m_flags;
    sb.push_back(e);
  endtask

  task automatic drive(input logic rst, input logic v, input logic [1:0] o,
                       input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    rst_n    = rst;
    in_valid = v;
    op       = o;
    num1     = a;
    num2     = b;
    model(rst, v, o, a, b);
  endtask

  // Drive one accepted op and check the post-edge outputs against literal expectations.
  task automatic drive_expect(input string name, input logic [1:0] o, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] er, input logic [3:0] ef);
    drive(1'b1, 1'b1, o, a, b);
    @(posedge clk);
    #2;
    chk({name, "_result"}, result, er);
    chk({name, "_flags"}, 32'(flags), 32'(ef));
  endtask

  // Monitor: one scoreboard entry per driven edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_out_valid", 32'(out_valid), 32'(e.v));
      chk("sb_result", result, e.r);
      chk("sb_flags", 32'(flags), 32'(e.f));
    end
  end

  function automatic logic [31:0] pick_operand();
    logic [31:0] s;
    case ($urandom_range(0, 7))
      0: s = 32'h0000_0000;
      1: s = 32'hFFFF_FFFF;
      2: s = 32'h7FFF_FFFF;
      3: s = 32'h8000_0000;
      default: s = $urandom;
    endcase
    return s;
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    m_res    = '0;
    m_flags  = '0;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    op       = 2'b10;
    num1     = 32'd5;
    num2     = 32'd6;

    drive(1'b0, 1'b1, 2'b10, 32'd5, 32'd6);
    drive(1'b0, 1'b1, 2'b10, 32'd5, 32'd6);
    @(posedge clk);
    #2;
    chk("reset_result", result, 32'd0);
    chk("reset_flags", 32'(flags), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);

    drive_expect("ands", 2'b00, 32'hF0F0_0000, 32'h8000_FFFF, 32'h8000_0000, 4'b0001);
    drive_expect("asr4", 2'b01, 32'h8000_0018, 32'd4, 32'hF800_0001, 4'b0101);
    drive_expect("asr0", 2'b01, 32'h8000_0018, 32'd0, 32'h8000_0018, 4'b0101);
    drive_expect("adds_ovf", 2'b10, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1001);
    drive_expect("ands_vkeep", 2'b00, 32'h0000_00FF, 32'h0000_0F00, 32'h0000_0000, 4'b1010);
    drive_expect("adds_carry", 2'b10, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0110);
    drive_expect("adcs_chain", 2'b11, 32'h0000_0000, 32'h0000_0000, 32'h0000_0001, 4'b0000);

    // Idle cycles with wiggling inputs must leave outputs frozen.
    drive(1'b1, 1'b1, 2'b10, 32'hFFFF_FFFF, 32'h0000_0002);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 2'(i), $urandom, $urandom);
    @(posedge clk);
    #2;
    chk("hold_result", result, 32'h0000_0001);
    chk("hold_flags", 32'(flags), 32'h4);
    chk("hold_out_valid", 32'(out_valid), 32'd0);

    // Mid-stream reset drops the request and clears C, so ADCS then acts as ADDS.
    drive(1'b0, 1'b1, 2'b11, 32'h1234_5678, 32'h1);
    drive_expect("adcs_after_rst", 2'b11, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 4'b0000);

    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 99) >= 3) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < 80) ? 1'b1 : 1'b0,
            2'($urandom_range(0, 3)), pick_operand(), pick_operand());
    end

    drive(1'b1, 1'b0, 2'b00, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #2;
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
